// File: rtl/mips_defs_pkg.sv
// Shared P7 core definitions: exception codes, reset/handler PCs, IM bounds, IF/ID fields.
// Combinational helpers only.
package mips_defs;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] HANDLER   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam int          IM_WORDS  = 4096;
  localparam logic [31:0] IM_LAST   = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [4:0]  exccode;
    logic        bd;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr: INSTR_NOP, pc: 32'h0, valid: 1'b0, exccode: EXC_NONE, bd: 1'b0
  };

  function automatic logic fetch_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register; one-cycle latency, stall holds contents.
// flush overrides stall and loads a bubble; reset also loads a bubble.
module if_id_reg
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic        valid_d,
  input  logic [4:0]  exccode_d,
  input  logic        bd_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q,
  output logic        valid_q,
  output logic [4:0]  exccode_q,
  output logic        bd_q
);

  if_id_t d, q_q;

  assign d = '{instr: instr_d, pc: pc_d, valid: valid_d, exccode: exccode_d, bd: bd_d};

  always_ff @(posedge clk) begin
    if (!reset_n)
      q_q <= IF_ID_BUBBLE;
    else if (flush)
      q_q <= IF_ID_BUBBLE;
    else if (!stall)
      q_q <= d;
  end

  assign instr_q   = q_q.instr;
  assign pc_q      = q_q.pc;
  assign valid_q   = q_q.valid;
  assign exccode_q = q_q.exccode;
  assign bd_q      = q_q.bd;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, fetch fault check, IF/ID register.
// Redirect visible on im_addr next cycle; stall freezes PC and IF/ID unless exc/eret.
module fetch_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_is_branch,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic        if_id_valid,
  output logic [4:0]  if_id_exccode,
  output logic        if_id_bd
);

  logic [31:0] pc_q, pc_d;
  logic        fault;
  logic        flush;

  // Priority: exception entry > eret > stall > branch > sequential.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (exc_req)
      pc_d = HANDLER;
    else if (eret_req)
      pc_d = epc;
    else if (stall)
      pc_d = pc_q;
    else if (br_taken)
      pc_d = br_target;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      pc_q <= PC_RESET;
    else
      pc_q <= pc_d;
  end

  // A faulting fetch still flows down as a valid nop so CP0 can raise AdEL in M.
  assign fault   = fetch_fault(pc_q);
  assign flush   = exc_req | eret_req;
  assign im_addr = pc_q;

  if_id_reg u_if_id (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .flush     (flush),
    .instr_d   (fault ? INSTR_NOP : im_instr),
    .pc_d      (pc_q),
    .valid_d   (1'b1),
    .exccode_d (fault ? EXC_ADEL : EXC_NONE),
    .bd_d      (br_taken | id_is_branch),
    .instr_q   (if_id_instr),
    .pc_q      (if_id_pc),
    .valid_q   (if_id_valid),
    .exccode_q (if_id_exccode),
    .bd_q      (if_id_bd)
  );

  assign if_id_pc8 = if_id_pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns a word tagged with its address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n, stall, br_taken, id_is_branch, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic [31:0] im_addr, im_instr;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc8;
  logic        if_id_valid, if_id_bd;
  logic [4:0]  if_id_exccode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign im_instr = {16'hAB00, im_addr[15:0]};

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .id_is_branch(id_is_branch), .exc_req(exc_req),
    .eret_req(eret_req), .epc(epc), .im_addr(im_addr), .im_instr(im_instr),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc8(if_id_pc8),
    .if_id_valid(if_id_valid), .if_id_exccode(if_id_exccode), .if_id_bd(if_id_bd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; id_is_branch = 0; exc_req = 0; eret_req = 0;
    br_target = 32'h0; epc = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    tick(); tick();
    checks++;
    if (im_addr !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp 00003000", im_addr); end
    checks++;
    if ({if_id_instr, if_id_pc, if_id_pc8, if_id_valid, if_id_exccode, if_id_bd} !== {32'h0, 32'h0, 32'h8, 1'b0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL reset_bubble got instr %h pc %h pc8 %h v %b exc %0d bd %b",
                         if_id_instr, if_id_pc, if_id_pc8, if_id_valid, if_id_exccode, if_id_bd);
    end
  endtask

  task automatic test_sequential();
    reset_n = 1;
    tick();
    checks++;
    if ({im_addr, if_id_pc, if_id_instr} !== {32'h3004, 32'h3000, 32'hAB00_3000}) begin
      errors++; $display("FAIL seq1 got im %h pc %h instr %h exp 3004/3000/ab003000", im_addr, if_id_pc, if_id_instr);
    end
    checks++;
    if ({if_id_valid, if_id_exccode, if_id_bd, if_id_pc8} !== {1'b1, 5'd0, 1'b0, 32'h3008}) begin
      errors++; $display("FAIL seq1_flags got v %b exc %0d bd %b pc8 %h", if_id_valid, if_id_exccode, if_id_bd, if_id_pc8);
    end
    tick();
    checks++;
    if ({im_addr, if_id_pc} !== {32'h3008, 32'h3004}) begin
      errors++; $display("FAIL seq2 got im %h pc %h exp 3008/3004", im_addr, if_id_pc);
    end
  endtask

  task automatic test_branch();
    id_is_branch = 1; br_taken = 1; br_target = 32'h3100;
    tick();
    idle();
    checks++;
    if ({im_addr, if_id_pc, if_id_bd} !== {32'h3100, 32'h3008, 1'b1}) begin
      errors++; $display("FAIL branch_slot got im %h pc %h bd %b exp 3100/3008/1", im_addr, if_id_pc, if_id_bd);
    end
    tick();
    checks++;
    if ({im_addr, if_id_pc, if_id_bd, if_id_instr} !== {32'h3104, 32'h3100, 1'b0, 32'hAB00_3100}) begin
      errors++; $display("FAIL branch_target got im %h pc %h bd %b instr %h", im_addr, if_id_pc, if_id_bd, if_id_instr);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({im_addr, if_id_pc, if_id_instr, if_id_valid} !== {32'h3104, 32'h3100, 32'hAB00_3100, 1'b1}) begin
        errors++; $display("FAIL stall_hold%0d got im %h pc %h instr %h v %b", i, im_addr, if_id_pc, if_id_instr, if_id_valid);
      end
    end
    stall = 0;
    tick();
    checks++;
    if ({im_addr, if_id_pc} !== {32'h3108, 32'h3104}) begin
      errors++; $display("FAIL stall_release got im %h pc %h exp 3108/3104", im_addr, if_id_pc);
    end
  endtask

  task automatic test_exc_eret();
    exc_req = 1; stall = 1; br_taken = 1; br_target = 32'h3200;
    tick();
    idle();
    checks++;
    if ({im_addr, if_id_valid, if_id_pc, if_id_pc8, if_id_instr, if_id_bd} !== {32'h4180, 1'b0, 32'h0, 32'h8, 32'h0, 1'b0}) begin
      errors++; $display("FAIL exc_entry got im %h v %b pc %h pc8 %h instr %h bd %b",
                         im_addr, if_id_valid, if_id_pc, if_id_pc8, if_id_instr, if_id_bd);
    end
    tick();
    checks++;
    if ({im_addr, if_id_pc, if_id_valid, if_id_exccode} !== {32'h4184, 32'h4180, 1'b1, 5'd0}) begin
      errors++; $display("FAIL handler_fetch got im %h pc %h v %b exc %0d", im_addr, if_id_pc, if_id_valid, if_id_exccode);
    end
    eret_req = 1; epc = 32'h3020; stall = 1;
    tick();
    idle();
    checks++;
    if ({im_addr, if_id_valid, if_id_pc} !== {32'h3020, 1'b0, 32'h0}) begin
      errors++; $display("FAIL eret got im %h v %b pc %h exp 3020/0/0", im_addr, if_id_valid, if_id_pc);
    end
    exc_req = 1; eret_req = 1; epc = 32'h3040;
    tick();
    idle();
    checks++;
    if ({im_addr, if_id_valid} !== {32'h4180, 1'b0}) begin
      errors++; $display("FAIL exc_over_eret got im %h v %b exp 4180/0", im_addr, if_id_valid);
    end
  endtask

  task automatic test_fault();
    br_taken = 1; br_target = 32'h3102;
    tick();
    idle();
    tick();
    checks++;
    if ({if_id_pc, if_id_instr, if_id_exccode, if_id_valid, im_addr} !== {32'h3102, 32'h0, 5'd4, 1'b1, 32'h3106}) begin
      errors++; $display("FAIL misalign got pc %h instr %h exc %0d v %b im %h",
                         if_id_pc, if_id_instr, if_id_exccode, if_id_valid, im_addr);
    end
    br_taken = 1; br_target = 32'h6FFC;
    tick();
    idle();
    tick();
    checks++;
    if ({if_id_pc, if_id_instr, if_id_exccode, im_addr} !== {32'h6FFC, 32'hAB00_6FFC, 5'd0, 32'h7000}) begin
      errors++; $display("FAIL last_legal got pc %h instr %h exc %0d im %h", if_id_pc, if_id_instr, if_id_exccode, im_addr);
    end
    tick();
    checks++;
    if ({if_id_pc, if_id_instr, if_id_exccode, im_addr} !== {32'h7000, 32'h0, 5'd4, 32'h7004}) begin
      errors++; $display("FAIL above_range got pc %h instr %h exc %0d im %h", if_id_pc, if_id_instr, if_id_exccode, im_addr);
    end
    br_taken = 1; br_target = 32'h2FFC;
    tick();
    idle();
    tick();
    checks++;
    if ({if_id_pc, if_id_exccode, im_addr} !== {32'h2FFC, 5'd4, 32'h3000}) begin
      errors++; $display("FAIL below_range got pc %h exc %0d im %h", if_id_pc, if_id_exccode, im_addr);
    end
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    tick();
    idle();
    tick();
    checks++;
    if (im_addr !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 00000000", im_addr); end
  endtask

  task automatic test_reset_dominates();
    reset_n = 0; exc_req = 1; stall = 1; br_taken = 1; br_target = 32'h3300;
    tick();
    idle();
    checks++;
    if ({im_addr, if_id_valid, if_id_pc} !== {32'h3000, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_wins got im %h v %b pc %h exp 3000/0/0", im_addr, if_id_valid, if_id_pc);
    end
    reset_n = 1;
    tick();
    checks++;
    if ({im_addr, if_id_pc, if_id_valid} !== {32'h3004, 32'h3000, 1'b1}) begin
      errors++; $display("FAIL post_reset got im %h pc %h v %b", im_addr, if_id_pc, if_id_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_exc_eret();
    test_fault();
    test_reset_dominates();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

IF stage of the P7 pipelined MIPS core: owns the PC register, the next-PC selection and the IF/ID pipeline register. Drives the word address into the instruction memory (text base 0x0000_3000, handler image at 0x0000_4180) and latches the returned word, its PC and fetch-exception status for ID. Redirect sources are branch/jump resolution in ID, CP0 exception entry and `eret`.

## Interface
- `PC_RESET`, 32'h0000_3000, PC value after reset.
- `HANDLER`, 32'h0000_4180, exception entry PC.
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address.
- `IM_WORDS`, 4096, instruction-memory depth in words; legal range is `IM_BASE` to `IM_BASE + 4*IM_WORDS - 4`.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `stall` in 1: hazard unit, hold PC and IF/ID.
- `br_taken` in 1: ID resolved a taken branch/jump.
- `br_target` in 32: target for `br_taken`.
- `id_is_branch` in 1: instruction currently in ID is a branch/jump, so the instruction being fetched is its delay slot.
- `exc_req` in 1: CP0 takes an exception/interrupt this cycle.
- `eret_req` in 1: `eret` is committing this cycle.
- `epc` in 32: CP0 EPC, return target for `eret`.
- `im_addr` out 32: current PC, to instruction memory (combinational read).
- `im_instr` in 32: instruction word at `im_addr`.
- `if_id_instr` out 32: latched instruction.
- `if_id_pc` out 32: PC of the latched instruction.
- `if_id_pc8` out 32: `if_id_pc + 8`, link value.
- `if_id_valid` out 1: 0 for a bubble.
- `if_id_exccode` out 5: 0 = none, 4 = AdEL on fetch.
- `if_id_bd` out 1: latched instruction is in a delay slot.

## Operation
- Fetch fault when `pc[1:0] != 0` or `pc` is outside the legal range. A faulting fetch latches `instr` 0 (nop), `exccode` 4, `valid` 1. The PC still advances normally and CP0 takes the fault when it reaches M.
- Next-PC priority, highest first:
  - `exc_req`: PC = `HANDLER`. IF/ID becomes a bubble. Overrides `stall`.
  - `eret_req`: PC = `epc`. IF/ID becomes a bubble. Overrides `stall`. `eret` has no delay slot.
  - `stall`: PC and IF/ID hold.
  - `br_taken`: PC = `br_target`. IF/ID latches the current fetch, which is the delay slot, with `bd` = 1.
  - Otherwise: PC = PC + 4, wrapping modulo 2^32. IF/ID latches the current fetch with `bd` = `id_is_branch`.
- Bubble: `instr` 0, `pc` 0, `pc8` 8, `valid` 0, `exccode` 0, `bd` 0.
- `exc_req` and `eret_req` together: `exc_req` wins.
- `br_target` and `epc` are not checked here. Misalignment is caught as a fetch fault on the following cycle.

## Timing
- Reset, sampled on an edge with `reset_n` = 0: PC = `PC_RESET`, IF/ID = bubble. `reset_n` dominates every other input, including mid-redirect and mid-stall.
- `im_addr` is combinational from the PC register. `im_instr` is valid in the same cycle.
- Redirect latency: a redirect asserted in cycle n puts the new PC on `im_addr` in cycle n+1. The target instruction appears on `if_id_*` in cycle n+2 if not stalled.
- With `stall` high for k cycles, `if_id_*` and `im_addr` stay constant for k cycles. Fetch resumes PC+4 after release.
- All outputs except `im_addr` and `if_id_pc8` are registers. `if_id_pc8` is combinational from `if_id_pc`.

## Structure
- Shared package / header `mips_defs`: `EXC_NONE` = 5'd0, `EXC_ADEL` = 5'd4, reset and handler PC constants, bubble instruction 32'h0. CP0 and the M stage use the same codes.
- Natural sub-module: `if_id_reg`, holding the pipeline register with `stall`/`flush` inputs and bubble insertion.
- Next-PC mux and fault check stay in `fetch_stage`.

## Test plan
- Reset, then release `reset_n` with no other input: `im_addr` runs 0x3000, 0x3004, 0x3008. `if_id_pc` lags one cycle, `valid` = 1, `exccode` = 0.
- `id_is_branch` = 1 and `br_taken` = 1 with `br_target` = 0x3100 while fetching 0x3008: `if_id_pc` = 0x3008 with `bd` = 1, next `im_addr` = 0x3100.
- `stall` high 3 cycles at PC 0x300C: `im_addr` and `if_id_*` frozen for 3 cycles, then 0x3010.
- `exc_req` together with `stall` and `br_taken`: next `im_addr` = 0x4180, IF/ID = bubble. `eret_req` with `epc` = 0x3020: next `im_addr` = 0x3020, bubble.
- `br_target` = 0x3102: `if_id_instr` = 0, `exccode` = 4. `br_target` = 0x7000 (out of range): `exccode` = 4. PC continues at +4.
- `reset_n` low during `exc_req`: PC = 0x3000, bubble. Reset wins.
